memory_unit: RTL and testbench

MEMORY_UNIT -- requirements
Module: memory_unit

---
 rtl/memory_unit.sv | 153 +++++++++++++++
 tb/tb_memory_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_unit.sv
// Memory unit: 256 x 8-bit big-endian byte store with a request/complete
// handshake (MFA -> MOC). Each request is captured in IDLE, waits a
// programmable number of cycles, performs one access, then holds MOC until
// the requester drops MFA.
//
// Ports:
//   CLK      in   system clock, rising-edge active
//   CLR      in   asynchronous active-low reset
//   MFA      in   memory function active (request)
//   RW       in   1 = read, 0 = write
//   DS       in   data size: 00 byte, 01 halfword, 10 word, 11 reserved
//   ADDR     in   byte address [7:0]
//   DATA_IN  in   write data [31:0]
//   DATA_OUT out  read data [31:0], holds until the next successful read
//   MOC      out  memory operation complete
//   ERR      out  completed request was misaligned or reserved (valid with MOC)
module memory_unit #(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        MFA,
  input  logic        RW,
  input  logic [1:0]  DS,
  input  logic [7:0]  ADDR,
  input  logic [31:0] DATA_IN,
  output logic [31:0] DATA_OUT,
  output logic        MOC,
  output logic        ERR
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                rw_q;
  logic [1:0]          ds_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         din_q;

  logic [7:0]          mem [DEPTH];

  logic [ADDR_W-1:0]   a1_c;
  logic [ADDR_W-1:0]   a2_c;
  logic [ADDR_W-1:0]   a3_c;
  logic                req_err_c;
  logic                wr_en_c;
  logic [31:0]         rd_word_c;

  // Byte lane addresses; aligned requests never wrap past 0xFF
  assign a1_c = ADDR_W'(addr_q + ADDR_W'(1));
  assign a2_c = ADDR_W'(addr_q + ADDR_W'(2));
  assign a3_c = ADDR_W'(addr_q + ADDR_W'(3));

  // Misaligned halfword/word or reserved size
  always_comb begin
    req_err_c = 1'b0;
    case (ds_q)
      2'b01:   req_err_c = addr_q[0];
      2'b10:   req_err_c = (addr_q[1:0] != 2'b00);
      2'b11:   req_err_c = 1'b1;
      default: req_err_c = 1'b0;
    endcase
  end

  assign wr_en_c   = (state == ACCESS) && !rw_q && !req_err_c;
  assign rd_word_c = {mem[addr_q], mem[a1_c], mem[a2_c], mem[a3_c]};

  // Storage array: no reset so contents survive CLR
  always_ff @(posedge CLK) begin
    if (wr_en_c) begin
      case (ds_q)
        2'b00: mem[addr_q] <= din_q[7:0];
        2'b01: begin
          mem[addr_q] <= din_q[15:8];
          mem[a1_c]   <= din_q[7:0];
        end
        default: begin
          mem[addr_q] <= din_q[31:24];
          mem[a1_c]   <= din_q[23:16];
          mem[a2_c]   <= din_q[15:8];
          mem[a3_c]   <= din_q[7:0];
        end
      endcase
    end
  end

  // Request sequencer with registered handshake outputs
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state    <= IDLE;
      cnt      <= '0;
      rw_q     <= 1'b0;
      ds_q     <= 2'b00;
      addr_q   <= '0;
      din_q    <= '0;
      MOC      <= 1'b0;
      ERR      <= 1'b0;
      DATA_OUT <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          if (MFA) begin
            rw_q   <= RW;
            ds_q   <= DS;
            addr_q <= ADDR;
            din_q  <= DATA_IN;
            cnt    <= CNT_W'(WAIT_STATES);
            state  <= (WAIT_STATES == 0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          // The edge that takes the counter to zero moves on to ACCESS
          cnt <= cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          MOC   <= 1'b1;
          ERR   <= req_err_c;
          state <= DONE;
          if (!req_err_c && rw_q) begin
            case (ds_q)
              2'b00:   DATA_OUT <= {24'h000000, mem[addr_q]};
              2'b01:   DATA_OUT <= {16'h0000, rd_word_c[31:16]};
              default: DATA_OUT <= rd_word_c;
            endcase
          end
        end
        DONE: begin
          // Hold completion until the requester withdraws MFA
          if (!MFA) begin
            MOC   <= 1'b0;
            ERR   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_unit.sv
// Testbench for memory_unit: randomized and directed requests against a
// byte-array reference model, with a scoreboard monitor checking every MOC
// completion (latency, ERR, DATA_OUT). A second instance covers zero waits.
module tb_memory_unit;

  localparam int unsigned WS = 2;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        MFA = 1'b0;
  logic        RW = 1'b0;
  logic [1:0]  DS = 2'b00;
  logic [7:0]  ADDR = 8'h00;
  logic [31:0] DATA_IN = 32'h0;
  logic [31:0] DATA_OUT;
  logic        MOC;
  logic        ERR;

  logic        mfa0 = 1'b0;
  logic        rw0 = 1'b0;
  logic [1:0]  ds0 = 2'b00;
  logic [7:0]  addr0 = 8'h00;
  logic [31:0] din0 = 32'h0;
  logic [31:0] dout0;
  logic        moc0;
  logic        err0;

  memory_unit #(.WAIT_STATES(WS)) dut (
    .CLK(CLK), .CLR(CLR), .MFA(MFA), .RW(RW), .DS(DS), .ADDR(ADDR),
    .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .MOC(MOC), .ERR(ERR)
  );

  memory_unit #(.WAIT_STATES(0)) dut_ws0 (
    .CLK(CLK), .CLR(CLR), .MFA(mfa0), .RW(rw0), .DS(ds0), .ADDR(addr0),
    .DATA_IN(din0), .DATA_OUT(dout0), .MOC(moc0), .ERR(err0)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain byte array, big-endian packing by size
  logic [7:0]  mem_m [256];
  logic [31:0] dout_m = 32'h0;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  function automatic logic model(input logic rw, input logic [1:0] ds, input logic [7:0] addr,
                                 input logic [31:0] din);
    int nb;
    int ai;
    logic e;
    logic [31:0] d;
    ai = int'(addr);
    e  = (ds == 2'b11) || (ds == 2'b01 && (ai % 2) != 0) || (ds == 2'b10 && (ai % 4) != 0);
    if (!e) begin
      nb = 1 << ds;
      if (rw) begin
        d = 32'h0;
        for (int i = 0; i < nb; i++) d = (d << 8) | {24'h0, mem_m[ai + i]};
        dout_m = d;
      end else begin
        for (int i = 0; i < nb; i++) mem_m[ai + i] = din[8*(nb-1-i) +: 8];
      end
    end
    return e;
  endfunction

  // Scoreboard monitor: every rising MOC must match the oldest expectation
  logic moc_prev = 1'b0;
  always @(negedge CLK) begin
    if (MOC && !moc_prev) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_moc", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("moc_latency", 32'(cyc), 32'(e.cyc));
        chk("err", {31'h0, ERR}, {31'h0, e.err});
        chk("data_out", DATA_OUT, e.data);
      end
    end
    moc_prev = MOC;
  end

  task automatic scramble();
    RW      = 1'($urandom);
    DS      = 2'($urandom);
    ADDR    = 8'($urandom);
    DATA_IN = $urandom;
  endtask

  // Issue one request starting at a negedge; hold MFA for 'hold' extra
  // cycles after MOC, or drop it right after capture when 'early' is set.
  task automatic issue(input logic rw, input logic [1:0] ds, input logic [7:0] addr,
                       input logic [31:0] din, input int hold, input bit early);
    exp_t e;
    int n;
    e.err  = model(rw, ds, addr, din);
    e.data = dout_m;
    e.cyc  = cyc + 1 + int'(WS) + 1;
    sb.push_back(e);
    MFA = 1'b1; RW = rw; DS = ds; ADDR = addr; DATA_IN = din;
    @(negedge CLK);
    scramble();
    if (early) MFA = 1'b0;
    n = 0;
    while (!MOC && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (!MOC) begin
      chk("moc_timeout", 32'd0, 32'd1);
      MFA = 1'b0;
      return;
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge CLK);
      scramble();
      chk("moc_hold", {31'h0, MOC}, 32'd1);
      chk("dout_hold", DATA_OUT, dout_m);
    end
    MFA = 1'b0;
    @(negedge CLK);
    chk("moc_clear", {31'h0, MOC}, 32'd0);
    chk("err_clear", {31'h0, ERR}, 32'd0);
  endtask

  task automatic issue0(input logic rw, input logic [1:0] ds, input logic [7:0] addr,
                        input logic [31:0] din, input logic [31:0] exp_data);
    int c0;
    int n;
    mfa0 = 1'b1; rw0 = rw; ds0 = ds; addr0 = addr; din0 = din;
    c0 = cyc + 1;
    n = 0;
    @(negedge CLK);
    addr0 = 8'($urandom);
    while (!moc0 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("ws0_latency", 32'(cyc), 32'(c0 + 1));
    chk("ws0_err", {31'h0, err0}, 32'd0);
    chk("ws0_data", dout0, exp_data);
    mfa0 = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ds;
    logic [7:0] a;
    int hold;

    repeat (3) @(negedge CLK);
    chk("rst_moc", {31'h0, MOC}, 32'd0);
    chk("rst_err", {31'h0, ERR}, 32'd0);
    chk("rst_dout", DATA_OUT, 32'h0);
    chk("rst_dout_ws0", dout0, 32'h0);
    CLR = 1'b1;
    @(negedge CLK);

    // Fill memory so every later read hits defined data
    for (int i = 0; i < 64; i++) issue(1'b0, 2'b10, 8'(i * 4), $urandom, 0, 1'b0);

    issue(1'b0, 2'b10, 8'h10, 32'hDEADBEEF, 0, 1'b0);
    issue(1'b1, 2'b10, 8'h10, 32'h0, 0, 1'b0);
    chk("word_read_10", DATA_OUT, 32'hDEADBEEF);
    issue(1'b1, 2'b00, 8'h11, 32'h0, 0, 1'b0);
    chk("byte_read_11", DATA_OUT, 32'h000000AD);
    issue(1'b1, 2'b01, 8'h12, 32'h0, 0, 1'b0);
    chk("half_read_12", DATA_OUT, 32'h0000BEEF);
    issue(1'b0, 2'b00, 8'h13, 32'h00000055, 0, 1'b0);
    issue(1'b1, 2'b10, 8'h10, 32'h0, 0, 1'b0);
    chk("word_read_after_byte", DATA_OUT, 32'hDEADBE55);
    issue(1'b1, 2'b10, 8'h11, 32'h0, 0, 1'b0);
    issue(1'b0, 2'b01, 8'h13, 32'hFFFF1234, 0, 1'b0);
    chk("dout_after_err", DATA_OUT, 32'hDEADBE55);
    issue(1'b1, 2'b11, 8'h10, 32'h0, 0, 1'b0);
    issue(1'b1, 2'b10, 8'h10, 32'h0, 0, 1'b0);
    chk("word_after_err", DATA_OUT, 32'hDEADBE55);

    // Reset mid-WAIT cancels the write
    MFA = 1'b1; RW = 1'b0; DS = 2'b10; ADDR = 8'h10; DATA_IN = 32'h12345678;
    @(negedge CLK);
    MFA = 1'b0;
    #2 CLR = 1'b0;
    #1;
    chk("rst_wait_moc", {31'h0, MOC}, 32'd0);
    chk("rst_wait_err", {31'h0, ERR}, 32'd0);
    chk("rst_wait_dout", DATA_OUT, 32'h0);
    dout_m = 32'h0;
    @(negedge CLK);
    CLR = 1'b1;
    issue(1'b1, 2'b10, 8'h10, 32'h0, 0, 1'b0);
    chk("read_after_rst", DATA_OUT, 32'hDEADBE55);

    // Long MFA hold, then early MFA drop
    issue(1'b1, 2'b01, 8'h12, 32'h0, 5, 1'b0);
    issue(1'b0, 2'b10, 8'h20, $urandom, 0, 1'b1);
    issue(1'b1, 2'b10, 8'h20, 32'h0, 0, 1'b1);

    // Randomized traffic, mostly aligned
    for (int i = 0; i < 150; i++) begin
      ds = 2'($urandom);
      a  = 8'($urandom);
      if (($urandom % 4) != 0) begin
        if (ds == 2'b01) a[0] = 1'b0;
        if (ds == 2'b10) a[1:0] = 2'b00;
      end
      hold = int'($urandom_range(0, 2));
      issue(1'($urandom), ds, a, $urandom, hold, (hold == 0) && (($urandom % 4) == 0));
    end

    // Zero-wait instance
    issue0(1'b0, 2'b10, 8'hFC, 32'hA1B2C3D4, 32'h0);
    issue0(1'b1, 2'b10, 8'hFC, 32'h0, 32'hA1B2C3D4);
    issue0(1'b1, 2'b00, 8'hFF, 32'h0, 32'h000000D4);

    repeat (3) @(negedge CLK);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
